// File: rtl/anton_neopixel_bus_arbiter_if.sv
// rtl/anton_neopixel_bus_arbiter_if.sv - two-master request bundle plus shared downstream bus
interface anton_neopixel_bus_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              m0_req;
    logic              m1_req;
    logic [ADDR_W-1:0] m0_addr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m0_dataIn;
    logic [DATA_W-1:0] m1_dataIn;
    logic              m0_write;
    logic              m1_write;
    logic              m0_read;
    logic              m1_read;
    logic              m0_lock;
    logic              m1_lock;
    logic              m0_ack;
    logic              m1_ack;
    logic [DATA_W-1:0] m0_dataOut;
    logic [DATA_W-1:0] m1_dataOut;
    logic [ADDR_W-1:0] busAddr;
    logic [DATA_W-1:0] busDataIn;
    logic              busWrite;
    logic              busRead;
    logic [DATA_W-1:0] busDataOut;

    // arbiter side
    modport slave (
        input  m0_req, m1_req, m0_addr, m1_addr, m0_dataIn, m1_dataIn,
               m0_write, m1_write, m0_read, m1_read, m0_lock, m1_lock, busDataOut,
        output m0_ack, m1_ack, m0_dataOut, m1_dataOut,
               busAddr, busDataIn, busWrite, busRead
    );

    // masters and registers block side
    modport master (
        output m0_req, m1_req, m0_addr, m1_addr, m0_dataIn, m1_dataIn,
               m0_write, m1_write, m0_read, m1_read, m0_lock, m1_lock, busDataOut,
        input  m0_ack, m1_ack, m0_dataOut, m1_dataOut,
               busAddr, busDataIn, busWrite, busRead
    );
endinterface

// File: rtl/anton_neopixel_bus_arbiter.sv
// rtl/anton_neopixel_bus_arbiter.sv - round-robin two-master arbiter, IDLE/ISSUE/ACK, optional lock via ANTON_NEOPIXEL_ARB_LOCK_EN
module anton_neopixel_bus_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input logic                   busClk,
    input logic                   busReset,
    anton_neopixel_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              grant;      // IDLE is accepting a transaction this cycle
    logic              pick;       // 0 = m0, 1 = m1
    logic              consider0;
    logic              consider1;
    logic              sel_wr;
    logic              sel_rd;
    logic              win;        // master owning the in-flight transaction
    logic              last;       // last master served
    logic              lat_wr;
    logic              lat_rd;
    logic [DATA_W-1:0] m0_rdata;
    logic [DATA_W-1:0] m1_rdata;
`ifdef ANTON_NEOPIXEL_ARB_LOCK_EN
    logic              hold_lock;  // last winner had lock high at its ACK
`endif

    // state register; reset abandons any in-flight transaction
    always_ff @(posedge busClk or posedge busReset) begin
        if (busReset) state <= IDLE;
        else          state <= state_nxt;
    end

    // next state, arbitration and all strobe/ack outputs
    always_comb begin
        state_nxt      = state;
        grant          = 1'b0;
        pick           = ~last;
        consider0      = bus.m0_req;
        consider1      = bus.m1_req;
        bus.busWrite   = 1'b0;
        bus.busRead    = 1'b0;
        bus.m0_ack     = 1'b0;
        bus.m1_ack     = 1'b0;
        bus.m0_dataOut = m0_rdata;
        bus.m1_dataOut = m1_rdata;
`ifdef ANTON_NEOPIXEL_ARB_LOCK_EN
        // a held lock narrows arbitration to the lock owner; the other master waits
        if (hold_lock && (last ? bus.m1_lock : bus.m0_lock)) begin
            consider0 = bus.m0_req & ~last;
            consider1 = bus.m1_req & last;
        end
`endif
        case (state)
            IDLE: begin
                if (consider0 || consider1) begin
                    grant     = 1'b1;
                    pick      = (consider0 && consider1) ? ~last : consider1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.busWrite = lat_wr;
                bus.busRead  = lat_rd;
                state_nxt    = ACK;
            end
            ACK: begin
                bus.m0_ack = ~win;
                bus.m1_ack = win;
                // registers block returns read data one cycle after the strobe, i.e. now
                if (lat_rd) begin
                    if (win) bus.m1_dataOut = bus.busDataOut;
                    else     bus.m0_dataOut = bus.busDataOut;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // write wins when both type bits are set
        sel_wr = pick ? bus.m1_write : bus.m0_write;
        sel_rd = (pick ? bus.m1_read : bus.m0_read) & ~sel_wr;
    end

    // latch the winner's transaction, hold read data, track fairness pointer
    always_ff @(posedge busClk or posedge busReset) begin
        if (busReset) begin
            bus.busAddr   <= '0;
            bus.busDataIn <= '0;
            win           <= 1'b0;
            last          <= 1'b1;
            lat_wr        <= 1'b0;
            lat_rd        <= 1'b0;
            m0_rdata      <= '0;
            m1_rdata      <= '0;
`ifdef ANTON_NEOPIXEL_ARB_LOCK_EN
            hold_lock     <= 1'b0;
`endif
        end else begin
            if (grant) begin
                win           <= pick;
                bus.busAddr   <= pick ? bus.m1_addr : bus.m0_addr;
                bus.busDataIn <= pick ? bus.m1_dataIn : bus.m0_dataIn;
                lat_wr        <= sel_wr;
                lat_rd        <= sel_rd;
            end
            if (state == ACK) begin
                last <= win;
`ifdef ANTON_NEOPIXEL_ARB_LOCK_EN
                hold_lock <= win ? bus.m1_lock : bus.m0_lock;
`endif
                if (lat_rd) begin
                    if (win) m1_rdata <= bus.busDataOut;
                    else     m0_rdata <= bus.busDataOut;
                end
            end
        end
    end
endmodule

// File: tb/tb_anton_neopixel_bus_arbiter.sv
// tb/tb_anton_neopixel_bus_arbiter.sv - self-checking bench for anton_neopixel_bus_arbiter
module tb_anton_neopixel_bus_arbiter;
    localparam int AW = 14;
    localparam int DW = 8;

    logic busClk = 1'b0;
    logic busReset;
    always #5 busClk = ~busClk;

    anton_neopixel_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    anton_neopixel_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .busClk   (busClk),
        .busReset (busReset),
        .bus      (bus)
    );

    // downstream registers block: write on strobe, registered read data
    logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};
    always @(posedge busClk) begin
        if (bus.busWrite) mem[bus.busAddr] <= bus.busDataIn;
        if (bus.busRead)  bus.busDataOut  <= mem[bus.busAddr];
    end

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int            last_m = 1;
    bit            lock_flag = 1'b0;
    logic [DW-1:0] held [2];
    logic [DW-1:0] ref_mem [int];
    time           ack_t = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick();
        bit r0 = bus.m0_req;
        bit r1 = bus.m1_req;
`ifdef ANTON_NEOPIXEL_ARB_LOCK_EN
        if (lock_flag && ((last_m == 0) ? bus.m0_lock : bus.m1_lock))
            return ((last_m == 0) ? r0 : r1) ? last_m : -1;
`endif
        if (r0 && r1) return 1 - last_m;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        last_m    = 1;
        lock_flag = 1'b0;
        held[0]   = '0;
        held[1]   = '0;
    endtask

    // starts at an IDLE-cycle negedge with inputs driven; ends at the next IDLE-cycle negedge
    task automatic run_txn(input bit drop_early, output int got);
        int            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            wr, rd;
        got = -1;
        w = model_pick();
        if (w < 0) begin
            @(negedge busClk);
            check("idle_quiet", {bus.busWrite, bus.busRead, bus.m0_ack, bus.m1_ack}, 0);
            return;
        end
        a  = (w == 1) ? bus.m1_addr : bus.m0_addr;
        d  = (w == 1) ? bus.m1_dataIn : bus.m0_dataIn;
        wr = (w == 1) ? bus.m1_write : bus.m0_write;
        rd = ((w == 1) ? bus.m1_read : bus.m0_read) && !wr;
        @(negedge busClk);
        check("issue_write", bus.busWrite, wr);
        check("issue_read", bus.busRead, rd);
        check("issue_addr", bus.busAddr, a);
        check("issue_data", bus.busDataIn, d);
        check("issue_noack", {bus.m0_ack, bus.m1_ack}, 0);
        if (drop_early) begin
            if (w == 1) bus.m1_req = 1'b0;
            else        bus.m0_req = 1'b0;
        end
        @(negedge busClk);
        if (rd) held[w] = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
        if (wr) ref_mem[int'(a)] = d;
        check("ack_m0", bus.m0_ack, w == 0);
        check("ack_m1", bus.m1_ack, w == 1);
        check("ack_strobes", {bus.busWrite, bus.busRead}, 0);
        check("dataout_m0", bus.m0_dataOut, held[0]);
        check("dataout_m1", bus.m1_dataOut, held[1]);
        got   = bus.m1_ack ? 1 : (bus.m0_ack ? 0 : -1);
        ack_t = $time;
        last_m    = w;
        lock_flag = (w == 1) ? bus.m1_lock : bus.m0_lock;
        @(negedge busClk);
        check("idle_after_ack", {bus.busWrite, bus.busRead, bus.m0_ack, bus.m1_ack}, 0);
    endtask

    task automatic set_m0(input bit rq, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit wr, input bit rd);
        bus.m0_req = rq; bus.m0_addr = a; bus.m0_dataIn = d; bus.m0_write = wr; bus.m0_read = rd;
    endtask

    task automatic set_m1(input bit rq, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit wr, input bit rd);
        bus.m1_req = rq; bus.m1_addr = a; bus.m1_dataIn = d; bus.m1_write = wr; bus.m1_read = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  got;
        time t_prev;
        int  exp_lock [5];
        busReset = 1'b1;
        set_m0(0, '0, '0, 0, 0);
        set_m1(0, '0, '0, 0, 0);
        bus.m0_lock = 1'b0;
        bus.m1_lock = 1'b0;
        model_reset();
        repeat (2) @(negedge busClk);
        check("rst_strobes", {bus.busWrite, bus.busRead}, 0);
        check("rst_addr", bus.busAddr, 0);
        check("rst_datain", bus.busDataIn, 0);
        check("rst_acks", {bus.m0_ack, bus.m1_ack}, 0);
        check("rst_dout0", bus.m0_dataOut, 0);
        check("rst_dout1", bus.m1_dataOut, 0);
        busReset = 1'b0;
        @(negedge busClk);

        // tie after reset: m0, m1, m0, m1, three cycles apart
        set_m0(1, 14'h0100, 8'h11, 1, 0);
        set_m1(1, 14'h0200, 8'h22, 1, 0);
        for (int i = 0; i < 4; i++) begin
            run_txn(0, got);
            check("tie_order", got, i % 2);
            if (i > 0) check("tie_spacing", ack_t - t_prev, 30);
            t_prev = ack_t;
        end
        set_m0(0, '0, '0, 0, 0);
        set_m1(0, '0, '0, 0, 0);
        @(negedge busClk);

        // single write
        set_m0(1, 14'h2000, 8'h05, 1, 0);
        run_txn(0, got);
        check("single_wr_who", got, 0);
        bus.m0_req = 1'b0;

        // preload then read from m1
        set_m0(1, 14'h0010, 8'hA5, 1, 0);
        run_txn(0, got);
        bus.m0_req = 1'b0;
        set_m1(1, 14'h0010, 8'h00, 0, 1);
        run_txn(0, got);
        check("read_who", got, 1);
        check("read_value", bus.m1_dataOut, 8'hA5);
        bus.m1_req = 1'b0;

        // write+read together on m1: write only, dataOut kept
        set_m1(1, 14'h0011, 8'h3C, 1, 1);
        run_txn(0, got);
        check("wr_rd_hold", bus.m1_dataOut, 8'hA5);
        bus.m1_req = 1'b0;

        // neither type bit: ack without strobe
        set_m0(1, 14'h0012, 8'h99, 0, 0);
        run_txn(0, got);
        check("no_type_who", got, 0);
        bus.m0_req = 1'b0;

        // request dropped during ISSUE still completes
        set_m0(1, 14'h0013, 8'h42, 1, 0);
        run_txn(1, got);
        check("drop_early_who", got, 0);

        // lock: make m1 last served, then m0 requests with lock
        set_m1(1, 14'h0011, 8'h00, 0, 1);
        run_txn(0, got);
        check("read_after_wr", bus.m1_dataOut, 8'h3C);
        set_m0(1, 14'h0014, 8'h01, 1, 0);
        set_m1(1, 14'h0015, 8'h02, 1, 0);
        bus.m0_lock = 1'b1;
`ifdef ANTON_NEOPIXEL_ARB_LOCK_EN
        exp_lock = '{0, 0, 0, 0, 1};
`else
        exp_lock = '{0, 1, 0, 1, 0};
`endif
        for (int i = 0; i < 5; i++) begin
            if (i == 4) bus.m0_lock = 1'b0;
            run_txn(0, got);
            check("lock_order", got, exp_lock[i]);
        end
        set_m0(0, '0, '0, 0, 0);
        set_m1(0, '0, '0, 0, 0);
        @(negedge busClk);

        // reset in the middle of ISSUE
        set_m0(1, 14'h0123, 8'h77, 1, 0);
        @(negedge busClk);
        check("mid_issue_write", bus.busWrite, 1);
        busReset = 1'b1;
        #1;
        check("mid_rst_write", bus.busWrite, 0);
        check("mid_rst_addr", bus.busAddr, 0);
        @(negedge busClk);
        check("mid_rst_noack", {bus.m0_ack, bus.m1_ack}, 0);
        check("mid_rst_dout1", bus.m1_dataOut, 0);
        bus.m0_req = 1'b0;
        model_reset();
        busReset = 1'b0;
        @(negedge busClk);
        set_m0(1, 14'h0016, 8'h10, 1, 0);
        set_m1(1, 14'h0017, 8'h20, 1, 0);
        run_txn(0, got);
        check("post_rst_tie", got, 0);
        check("mem_untouched", mem[14'h0123], 0);

        // randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            set_m0(($urandom % 4) != 0, 14'($urandom % 16), 8'($urandom), $urandom % 2, $urandom % 2);
            set_m1(($urandom % 4) != 0, 14'($urandom % 16), 8'($urandom), $urandom % 2, $urandom % 2);
            bus.m0_lock = ($urandom % 3) == 0;
            bus.m1_lock = ($urandom % 3) == 0;
            run_txn(0, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/anton_neopixel_bus_arbiter.md
ANTON_NEOPIXEL_BUS_ARBITER -- requirements
Module: anton_neopixel_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, width of the register/pixel-buffer address bus.
REQ-002 SHALL have parameter DATA_W, default 8, width of the data bus.
REQ-003 busClk  input  1  the single clock; all state changes on its rising edge.
REQ-004 busReset  input  1  asynchronous, active-high reset.
REQ-005 m0_req, m1_req  input  1 each  master request; held high until the matching ack.
REQ-006 m0_addr, m1_addr  input  ADDR_W each  transaction address; stable while req is high.
REQ-007 m0_dataIn, m1_dataIn  input  DATA_W each  write data.
REQ-008 m0_write, m1_write, m0_read, m1_read  input  1 each  transaction type.
REQ-009 m0_lock, m1_lock  input  1 each  burst-lock request; used only per REQ-027.
REQ-010 m0_ack, m1_ack  output  1 each  one-cycle completion pulse.
REQ-011 m0_dataOut, m1_dataOut  output  DATA_W each  read data, valid while the matching ack is high.
REQ-012 busAddr  output  ADDR_W, busDataIn  output  DATA_W, busWrite  output  1, busRead  output  1: shared downstream bus to the registers block.
REQ-013 busDataOut  input  DATA_W  registered read data from the registers block, valid one cycle after busRead.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, ISSUE, ACK.
REQ-015 IDLE: with no req high, stay IDLE; otherwise latch the winner's index, addr, data and type, go to ISSUE.
REQ-016 ISSUE: drive latched addr/data on busAddr/busDataIn and assert exactly one of busWrite/busRead for exactly one cycle; go to ACK.
REQ-017 ACK: pulse the winner's ack for one cycle; for reads, drive busDataOut onto the winner's dataOut in the same cycle; update last-served pointer; go to IDLE.
REQ-018 Latency: req sampled high in IDLE at edge N -> bus strobe cycle N+1 -> ack cycle N+2; max throughput one transaction per 3 cycles.
REQ-019 Arbitration SHALL be round-robin: when both req high in IDLE, the master not last served wins; a single requester always wins.
REQ-020 Without lock, a continuously requesting master SHALL wait at most one other transaction.
REQ-021 busWrite and busRead SHALL be low in IDLE and ACK; busAddr/busDataIn hold last issued values outside ISSUE.
REQ-022 If write and read are both high, SHALL issue a write only; ack still pulses; dataOut unchanged.
REQ-023 If neither write nor read is high, SHALL issue no strobe but still complete ISSUE->ACK with an ack.
REQ-024 If req drops before ack, the latched transaction SHALL complete and ack SHALL still pulse.
REQ-025 dataOut of each master SHALL hold its last read value until its next read ack.

Reset
REQ-026 On busReset high, immediately and regardless of state: FSM=IDLE, busWrite=0, busRead=0, busAddr=0, busDataIn=0, both acks=0, both dataOut=0, last-served pointer=m1 (so m0 wins first tie); an in-flight transaction is abandoned without ack.

Configuration
REQ-027 Macro ANTON_NEOPIXEL_ARB_LOCK_EN defined: if the winner's lock is high at its ACK cycle, the next IDLE arbitration SHALL consider only that master while its lock stays high, the other master waiting; lock low restores round-robin.
REQ-028 Macro undefined: m0_lock/m1_lock ports present but ignored; pure round-robin.

Verification
REQ-029 Single write: m0 write addr 0x2000 data 0x05 -> busWrite high 1 cycle with busAddr=0x2000, busDataIn=0x05; m0_ack two cycles after request sampled.
REQ-030 Read: preload pixel 0x0010=0xA5, m1 read 0x0010 -> m1_ack with m1_dataOut=0xA5; m0_ack stays low.
REQ-031 Tie after reset: m0 and m1 request together continuously -> grant order m0, m1, m0, m1; each ack 3 cycles apart.
REQ-032 Lock (macro defined): m0_lock=1, both requesting for 4 transactions -> m0 served 4 times, m1 waits; lock drop -> m1 served next; macro undefined -> alternation.
REQ-033 Reset mid-op: busReset asserted during ISSUE -> busWrite drops same cycle, no ack, FSM IDLE, m0 wins next tie.
REQ-034 Write+read both high on m1 -> busWrite only, busRead never high, m1_ack pulses, m1_dataOut unchanged.
